// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer: FSM encoding,
// funct3 access sizes, the latched access record and the legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } access_t;

  // Unsigned sizes exist only for loads; halves and words must be naturally aligned.
  function automatic logic access_ok(input logic ld, input logic [2:0] f3,
                                     input logic [1:0] a);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return !a[0];
      F3_W:    return (a == 2'b00);
      F3_BU:   return ld;
      F3_HU:   return ld && !a[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/grant/read-valid bus between the LSU (master) and memory (slave).
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and lane replication, load
// lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    be        = 4'b0000;
    wdata_out = wdata;
    rdata_ext = '0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_out = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
      end
      F3_W: begin
        be        = 4'b1111;
        rdata_ext = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Multicycle load/store sequencer: IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
// Define LSU_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT_CYC cycles.
module lsu_ctrl
  import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYC = 255
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata_out,
  lsu_if.master       mem
);

  state_e      state_q, state_d;
  access_t     acc_q, acc_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_w;
  logic [31:0] wdata_w, rdata_ext;
  logic        in_req;

  lsu_align u_align (
    .funct3    (acc_q.funct3),
    .addr_lo   (acc_q.addr[1:0]),
    .wdata     (acc_q.wdata),
    .rdata     (mem.mem_rdata),
    .be        (be_w),
    .wdata_out (wdata_w),
    .rdata_ext (rdata_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)                         cnt_d = '0;
    else if (state_q == REQ || state_q == WAIT)  cnt_d = cnt_q + 1'b1;
  end

  // Abort only when the pending handshake step did not complete this cycle.
  assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1)) &&
                   ((state_q == REQ && !mem.mem_gnt) || (state_q == WAIT && !mem.mem_rvalid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (start && (is_load ^ is_store)) begin
          acc_d.is_load = is_load;
          acc_d.funct3  = funct3;
          acc_d.addr    = addr;
          acc_d.wdata   = wdata;
          if (access_ok(is_load, funct3, addr[1:0])) begin
            err_d   = 1'b0;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      REQ:  if (mem.mem_gnt) state_d = acc_q.is_load ? WAIT : DONE;
      WAIT: begin
        if (mem.mem_rvalid) begin
          rdata_d = rdata_ext;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LSU_TIMEOUT_EN
    if (expired) begin
      err_d   = 1'b1;
      rdata_d = '0;
      state_d = DONE;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_req    = (state_q == REQ);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = done & err_q;
  assign rdata_out = rdata_q;

  // Bus fields are zero outside REQ so an aborted or idle LSU presents a quiet bus.
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req & ~acc_q.is_load;
  assign mem.mem_addr  = in_req ? {acc_q.addr[31:2], 2'b00} : 32'h0;
  assign mem.mem_be    = in_req ? be_w : 4'b0000;
  assign mem.mem_wdata = (in_req && !acc_q.is_load) ? wdata_w : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl; the timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        busy, done, err;
  logic [31:0] rdata_out;
  int          vectors = 0;
  int          miscompares = 0;

  lsu_if mem ();

  lsu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_load   (is_load),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata_out (rdata_out),
    .mem       (mem)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    start = 1'b1; is_load = ld; is_store = !ld; funct3 = f3; addr = a; wdata = wd;
    tick();
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({busy, done, err, rdata_out, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be,
         mem.mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b rdata=%h req=%b we=%b addr=%h be=%b wdata=%h, all must be 0",
               busy, done, err, rdata_out, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be, mem.mem_wdata);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    issue(1'b1, F3_W, 32'h104, 32'h0);
    vectors++;
    if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be, busy} !== {1'b1, 1'b0, 32'h104, 4'hF, 1'b1}) begin
      miscompares++;
      $display("FAIL lw_req: req=%b we=%b addr=%h be=%b busy=%b, expected 1 0 00000104 1111 1",
               mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be, busy);
    end
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0;
    vectors++;
    if ({mem.mem_req, busy, done} !== 3'b010) begin
      miscompares++;
      $display("FAIL lw_wait: req=%b busy=%b done=%b, expected 0 1 0", mem.mem_req, busy, done);
    end
    mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hDEADBEEF;
    tick();
    mem.mem_rvalid = 1'b0;
    vectors++;
    if ({done, err, rdata_out} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL lw_done_cycle3: done=%b err=%b rdata=%h, expected 1 0 deadbeef", done, err, rdata_out);
    end
    tick();
    vectors++;
    if ({done, busy, rdata_out} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL lw_hold: done=%b busy=%b rdata=%h, expected 0 0 deadbeef", done, busy, rdata_out);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s  [5] = '{F3_B, F3_BU, F3_HU, F3_H, F3_B};
    logic [31:0] adrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h102};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, f3s[i], adrs[i], 32'h0);
      mem.mem_gnt = 1'b1;
      tick();
      mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h80FF_0000;
      tick();
      mem.mem_rvalid = 1'b0;
      vectors++;
      if ({done, err, rdata_out} !== {1'b1, 1'b0, exps[i]}) begin
        miscompares++;
        $display("FAIL load_extend[%0d]: done=%b err=%b rdata=%h, expected 1 0 %h",
                 i, done, err, rdata_out, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s [3] = '{F3_B, F3_W, F3_B};
    logic [31:0] adrs[3] = '{32'h203, 32'h300, 32'h201};
    logic [31:0] wds [3] = '{32'h000000EF, 32'h01020304, 32'h0000005A};
    logic [3:0]  bes [3] = '{4'b1000, 4'b1111, 4'b0010};
    logic [31:0] lns [3] = '{32'hEFEFEFEF, 32'h01020304, 32'h5A5A5A5A};
    int req_cycles = 0;
    issue(1'b0, F3_H, 32'h202, 32'h1234ABCD);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be, mem.mem_wdata, done} !==
          {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b0}) begin
        miscompares++;
        $display("FAIL sh_req[%0d]: req=%b we=%b addr=%h be=%b wdata=%h done=%b, expected 1 1 00000200 1100 abcdabcd 0",
                 i, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be, mem.mem_wdata, done);
      end
      if (mem.mem_req) req_cycles++;
      if (i == 3) mem.mem_gnt = 1'b1;
      tick();
    end
    mem.mem_gnt = 1'b0;
    vectors++;
    if (req_cycles != 4 || {done, err, mem.mem_req} !== 3'b100) begin
      miscompares++;
      $display("FAIL sh_done: req_cycles=%0d done=%b err=%b req=%b, expected 4 1 0 0",
               req_cycles, done, err, mem.mem_req);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, f3s[i], adrs[i], wds[i]);
      vectors++;
      if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be, mem.mem_wdata} !==
          {1'b1, 1'b1, {adrs[i][31:2], 2'b00}, bes[i], lns[i]}) begin
        miscompares++;
        $display("FAIL store_lanes[%0d]: req=%b we=%b addr=%h be=%b wdata=%h, expected be=%b wdata=%h",
                 i, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be, mem.mem_wdata, bes[i], lns[i]);
      end
      mem.mem_gnt = 1'b1;
      tick();
      mem.mem_gnt = 1'b0;
      vectors++;
      if ({done, err} !== 2'b10) begin
        miscompares++;
        $display("FAIL store_latency2[%0d]: done=%b err=%b, expected 1 0", i, done, err);
      end
      tick();
    end
  endtask

  task automatic test_misaligned();
    logic        lds [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{F3_W, F3_H, F3_W, F3_BU, 3'b011};
    logic [31:0] adrs[5] = '{32'h101, 32'h101, 32'h102, 32'h100, 32'h100};
    for (int i = 0; i < 5; i++) begin
      issue(lds[i], f3s[i], adrs[i], 32'hFFFF_FFFF);
      start = 1'b1; is_load = 1'b1; funct3 = F3_W; addr = 32'h104;
      vectors++;
      if ({done, err, rdata_out, mem.mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        miscompares++;
        $display("FAIL bad_access[%0d]: done=%b err=%b rdata=%h req=%b, expected 1 1 00000000 0",
                 i, done, err, rdata_out, mem.mem_req);
      end
      tick();
      start = 1'b0; is_load = 1'b0;
      vectors++;
      if ({busy, mem.mem_req, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL start_in_done_ignored[%0d]: busy=%b req=%b done=%b, expected 0 0 0",
                 i, busy, mem.mem_req, done);
      end
    end
    start = 1'b1; is_load = 1'b1; is_store = 1'b1; funct3 = F3_W; addr = 32'h104;
    tick();
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    vectors++;
    if ({busy, mem.mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL both_kinds_ignored: busy=%b req=%b, expected 0 0", busy, mem.mem_req);
    end
    issue(1'b1, F3_W, 32'h104, 32'h0);
    start = 1'b1; is_store = 1'b1; funct3 = F3_W; addr = 32'h300;
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0; start = 1'b0; is_store = 1'b0;
    mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h11223344;
    tick();
    mem.mem_rvalid = 1'b0;
    vectors++;
    if ({done, err, rdata_out} !== {1'b1, 1'b0, 32'h11223344}) begin
      miscompares++;
      $display("FAIL start_while_busy_load: done=%b err=%b rdata=%h, expected 1 0 11223344", done, err, rdata_out);
    end
    tick();
    vectors++;
    if ({busy, mem.mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL start_while_busy_ignored: busy=%b req=%b, expected 0 0", busy, mem.mem_req);
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, F3_W, 32'h104, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem.mem_req, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_in_req: req=%b busy=%b, expected 0 0", mem.mem_req, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    issue(1'b1, F3_W, 32'h104, 32'h0);
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, rdata_out, mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be,
         mem.mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_in_wait: busy=%b done=%b err=%b rdata=%h req=%b addr=%h be=%b, all must be 0",
               busy, done, err, rdata_out, mem.mem_req, mem.mem_addr, mem.mem_be);
    end
    tick();
    rst_n = 1'b1;
    mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({done, busy, rdata_out} !== {1'b0, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL late_rvalid_ignored[%0d]: done=%b busy=%b rdata=%h, expected 0 0 00000000",
                 i, done, busy, rdata_out);
      end
    end
    mem.mem_rvalid = 1'b0;
    tick();
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int n = 1;
    issue(1'b1, F3_W, 32'h104, 32'h0);
    while (!done && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 256 || {done, err, rdata_out, mem.mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout: done at cycle %0d done=%b err=%b rdata=%h req=%b, expected cycle 256 1 1 00000000 0",
               n, done, err, rdata_out, mem.mem_req);
    end
    tick();
    vectors++;
    if ({busy, mem.mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_after: busy=%b req=%b, expected 0 0", busy, mem.mem_req);
    end
  endtask
`else
  task automatic test_no_timeout();
    issue(1'b0, F3_W, 32'h300, 32'h0A0B0C0D);
    repeat (300) tick();
    vectors++;
    if ({mem.mem_req, busy, done} !== 3'b110) begin
      miscompares++;
      $display("FAIL wait_indefinitely: req=%b busy=%b done=%b, expected 1 1 0", mem.mem_req, busy, done);
    end
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0;
    vectors++;
    if ({done, err} !== 2'b10) begin
      miscompares++;
      $display("FAIL late_gnt_done: done=%b err=%b, expected 1 0", done, err);
    end
    tick();
  endtask
`endif

  initial begin
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'h0;
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_misaligned();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
